// File: rtl/line_window_buffer.sv
// Raster-to-column line buffer: emits the current pixel stacked with the same
// column from the previous ROWS-1 lines, with valid/ready flow control on both sides.
module line_window_buffer #(
  parameter  int DATA_W   = 32,
  parameter  int LINE_W   = 640,
  parameter  int ROWS     = 3,
  parameter  int PAD_MODE = 0,
  localparam int CW       = $clog2(LINE_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_data_valid,
  input  logic                     in_sof,
  output logic                     ou_up_ready,
  output logic [ROWS*DATA_W-1:0]   ou_col,
  output logic                     ou_valid,
  input  logic                     in_dn_ready,
  output logic [CW-1:0]            ou_col_idx,
  output logic                     ou_eol,
  output logic                     ou_primed
);

  localparam int              LDW      = $clog2(ROWS);
  localparam logic [CW-1:0]   LAST_COL = CW'(LINE_W - 1);
  localparam logic [LDW-1:0]  FULL_LD  = LDW'(ROWS - 1);

  logic [CW-1:0]            r_col_p0;
  logic [LDW-1:0]           r_ld_p0;
  logic [DATA_W-1:0]        r_mem [ROWS-1][LINE_W];

  logic                     r_vld_p1;
  logic [ROWS*DATA_W-1:0]   r_col_p1;
  logic [CW-1:0]            r_idx_p1;
  logic                     r_eol_p1;

  logic                     w_accept;
  logic                     w_emit;
  logic                     w_last;
  logic [CW-1:0]            w_c;
  logic [LDW-1:0]           w_ld;
  logic [ROWS*DATA_W-1:0]   w_col_p0;

  function automatic logic [LDW-1:0] sat_inc(input logic [LDW-1:0] v);
    return (v == FULL_LD) ? v : v + LDW'(1);
  endfunction

  // A start-of-frame beat is treated as column 0 of line 0, overriding any wrap.
  assign w_c         = in_sof ? '0 : r_col_p0;
  assign w_ld        = in_sof ? '0 : r_ld_p0;
  assign w_last      = (w_c == LAST_COL);
  assign ou_up_ready = !r_vld_p1 || in_dn_ready;
  assign w_accept    = in_data_valid && ou_up_ready;
  assign w_emit      = (PAD_MODE != 0) || (w_ld == FULL_LD);

  always_comb begin
    w_col_p0                = '0;
    w_col_p0[DATA_W-1:0]    = in_data;
    for (int k = 1; k < ROWS; k++) begin
      if (PAD_MODE == 0 || k <= int'(w_ld))
        w_col_p0[k*DATA_W +: DATA_W] = r_mem[k-1][w_c];
    end
  end

  // Stage p0: column/line counters and line memories
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_p0 <= '0;
      r_ld_p0  <= '0;
    end else if (w_accept) begin
      r_col_p0 <= w_last ? '0 : w_c + CW'(1);
      r_ld_p0  <= w_last ? sat_inc(w_ld) : w_ld;
    end
  end

  // Non-blocking writes keep reads of the old line contents for this beat.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[0][w_c] <= in_data;
      for (int k = 1; k < ROWS-1; k++)
        r_mem[k][w_c] <= r_mem[k-1][w_c];
    end
  end

  // Stage p1: output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_col_p1 <= '0;
      r_idx_p1 <= '0;
      r_eol_p1 <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1 <= w_emit;
      if (w_emit) begin
        r_col_p1 <= w_col_p0;
        r_idx_p1 <= w_c;
        r_eol_p1 <= w_last;
      end
    end else if (in_dn_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign ou_valid   = r_vld_p1;
  assign ou_col     = r_col_p1;
  assign ou_col_idx = r_idx_p1;
  assign ou_eol     = r_eol_p1;
  assign ou_primed  = (r_ld_p0 == FULL_LD);

endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: three instances (pad-off, pad-on, wide/tall) checked
// every cycle against a frame-history model, plus directed literal expectations.
module tb_line_window_buffer;

  logic clk = 1'b0;
  logic rst;

  logic [7:0] in_data  [3];
  logic       in_valid [3];
  logic       in_sof   [3];
  logic       dn_ready [3];
  logic       up_ready [3];
  logic       valid    [3];
  logic       eol      [3];
  logic       primed   [3];
  logic [23:0] col0, col1;
  logic [39:0] col2;
  logic [1:0]  idx0, idx1;
  logic [9:0]  idx2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_window_buffer #(.DATA_W(8), .LINE_W(4), .ROWS(3), .PAD_MODE(0)) u_d0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_data_valid(in_valid[0]),
    .in_sof(in_sof[0]), .ou_up_ready(up_ready[0]), .ou_col(col0), .ou_valid(valid[0]),
    .in_dn_ready(dn_ready[0]), .ou_col_idx(idx0), .ou_eol(eol[0]), .ou_primed(primed[0]));

  line_window_buffer #(.DATA_W(8), .LINE_W(4), .ROWS(3), .PAD_MODE(1)) u_d1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_data_valid(in_valid[1]),
    .in_sof(in_sof[1]), .ou_up_ready(up_ready[1]), .ou_col(col1), .ou_valid(valid[1]),
    .in_dn_ready(dn_ready[1]), .ou_col_idx(idx1), .ou_eol(eol[1]), .ou_primed(primed[1]));

  line_window_buffer #(.DATA_W(8), .LINE_W(640), .ROWS(5), .PAD_MODE(1)) u_d2 (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_data_valid(in_valid[2]),
    .in_sof(in_sof[2]), .ou_up_ready(up_ready[2]), .ou_col(col2), .ou_valid(valid[2]),
    .in_dn_ready(dn_ready[2]), .ou_col_idx(idx2), .ou_eol(eol[2]), .ou_primed(primed[2]));

  // Model: every pixel of the current frame is remembered by (line, column).
  int LWv [3]  = '{4, 4, 640};
  int Rv  [3]  = '{3, 3, 5};
  int PADv[3]  = '{0, 1, 1};
  int          m_line [3];
  int          m_col  [3];
  int          m_ep   [3];
  bit          m_vld  [3];
  logic [39:0] m_out  [3];
  int          m_idx  [3];
  bit          m_eol  [3];
  logic [7:0]  hist [longint];

  logic [50:0] q0[$], q1[$];
  int          eolcnt2 = 0;
  bit          rr_en [3];

  function automatic longint key(input int d, input int ep, input int ln, input int c);
    return ((longint'(d) * 65536 + longint'(ep)) * 65536 + longint'(ln)) * 1024 + longint'(c);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        m_line[d] = 0; m_col[d] = 0; m_ep[d]++;
        m_vld[d] = 0; m_out[d] = '0; m_idx[d] = 0; m_eol[d] = 0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (in_valid[d] && (!m_vld[d] || dn_ready[d])) begin
          logic [39:0] o;
          if (in_sof[d]) begin
            m_ep[d]++; m_line[d] = 0; m_col[d] = 0;
          end
          hist[key(d, m_ep[d], m_line[d], m_col[d])] = in_data[d];
          o = '0;
          o[7:0] = in_data[d];
          for (int k = 1; k < Rv[d]; k++)
            if (m_line[d] - k >= 0)
              o[k*8 +: 8] = hist[key(d, m_ep[d], m_line[d] - k, m_col[d])];
          if (PADv[d] != 0 || m_line[d] >= Rv[d] - 1) begin
            m_vld[d] = 1; m_out[d] = o; m_idx[d] = m_col[d];
            m_eol[d] = (m_col[d] == LWv[d] - 1);
          end else begin
            m_vld[d] = 0;
          end
          m_col[d]++;
          if (m_col[d] == LWv[d]) begin
            m_col[d] = 0; m_line[d]++;
          end
        end else if (dn_ready[d]) begin
          m_vld[d] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      logic [39:0] ac;
      logic [9:0]  ai;
      case (d)
        0:       begin ac = {16'h0, col0}; ai = {8'h0, idx0}; end
        1:       begin ac = {16'h0, col1}; ai = {8'h0, idx1}; end
        default: begin ac = col2;          ai = idx2;         end
      endcase
      chk($sformatf("d%0d up_ready", d), 64'(up_ready[d]), 64'(!m_vld[d] || dn_ready[d]));
      chk($sformatf("d%0d valid", d), 64'(valid[d]), 64'(m_vld[d]));
      if (m_vld[d]) begin
        chk($sformatf("d%0d col", d), 64'(ac), 64'(m_out[d]));
        chk($sformatf("d%0d col_idx", d), 64'(ai), 64'(m_idx[d]));
        chk($sformatf("d%0d eol", d), 64'(eol[d]), 64'(m_eol[d]));
      end
      chk($sformatf("d%0d primed", d), 64'(primed[d]), 64'(m_line[d] >= Rv[d] - 1));
      if (valid[d] && dn_ready[d]) begin
        if (d == 0) q0.push_back({eol[d], ai, ac});
        if (d == 1) q1.push_back({eol[d], ai, ac});
        if (d == 2 && eol[d]) eolcnt2++;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++)
      if (rr_en[d]) dn_ready[d] = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input int d, input logic [7:0] v, input bit sof);
    bit acc;
    int n;
    in_data[d] = v; in_valid[d] = 1'b1; in_sof[d] = sof;
    acc = 0; n = 0;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = up_ready[d];
      @(posedge clk); #1;
      n++;
    end
    in_valid[d] = 1'b0; in_sof[d] = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL beat_timeout d%0d: no accept in %0d cycles, required accept", d, n);
    end
  endtask

  task automatic rand_stream(input int d, input int n, input int sofrate);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      beat(d, 8'($urandom), (sofrate > 0) && ($urandom_range(0, sofrate - 1) == 0));
    end
  endtask

  initial begin
    int n0;
    for (int d = 0; d < 3; d++) begin
      in_data[d] = '0; in_valid[d] = 0; in_sof[d] = 0; dn_ready[d] = 1; rr_en[d] = 0;
    end
    rst = 1'b1;
    #2;
    chk("reset valid", 64'(valid[0]), 64'h0);
    chk("reset col", 64'(col0), 64'h0);
    chk("reset idx", 64'(idx0), 64'h0);
    chk("reset eol", 64'(eol[0]), 64'h0);
    chk("reset primed", 64'(primed[0]), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Pad-off stream of three lines
    for (int i = 1; i <= 12; i++) begin
      beat(0, 8'(i), i == 1);
      if (i == 7) chk("t1 primed after 7", 64'(primed[0]), 64'h0);
      if (i == 8) chk("t1 primed after 8", 64'(primed[0]), 64'h1);
    end
    idle(2);
    chk("t1 out count", 64'(q0.size()), 64'd4);
    chk("t1 first col", 64'(q0[0][39:0]), 64'h010509);
    chk("t1 first idx", 64'(q0[0][49:40]), 64'h0);
    chk("t1 first eol", 64'(q0[0][50]), 64'h0);
    chk("t1 last col", 64'(q0[3][39:0]), 64'h04080c);
    chk("t1 last eol", 64'(q0[3][50]), 64'h1);

    // Pad-on stream, then backpressure
    for (int i = 1; i <= 12; i++) beat(1, 8'(i), i == 1);
    dn_ready[1] = 0; in_data[1] = 8'd13; in_valid[1] = 1; in_sof[1] = 0;
    repeat (3) begin
      @(negedge clk);
      chk("bp up_ready", 64'(up_ready[1]), 64'h0);
      chk("bp valid", 64'(valid[1]), 64'h1);
      chk("bp col held", 64'(col1), 64'h04080c);
      @(posedge clk); #1;
    end
    dn_ready[1] = 1;
    @(posedge clk); #1;
    in_valid[1] = 0;
    for (int i = 14; i <= 16; i++) beat(1, 8'(i), 0);
    idle(2);
    chk("t3 out count", 64'(q1.size()), 64'd16);
    chk("t2 beat1 col", 64'(q1[0][39:0]), 64'h000001);
    chk("t2 beat5 col", 64'(q1[4][39:0]), 64'h000105);
    chk("t2 beat9 col", 64'(q1[8][39:0]), 64'h010509);
    chk("t2 beat12 eol", 64'(q1[11][50]), 64'h1);
    chk("t2 beat12 idx", 64'(q1[11][49:40]), 64'h3);
    chk("t3 beat13 col", 64'(q1[12][39:0]), 64'h05090d);

    // Frame restart on the 3rd pixel of line 3
    for (int i = 1; i <= 10; i++) beat(0, 8'(i), i == 1);
    idle(2);
    n0 = q0.size();
    chk("t4 out before sof", 64'(n0), 64'd6);
    chk("t4 primed before sof", 64'(primed[0]), 64'h1);
    beat(0, 8'd100, 1);
    chk("t4 primed after sof", 64'(primed[0]), 64'h0);
    for (int i = 101; i <= 107; i++) beat(0, 8'(i), 0);
    idle(2);
    chk("t4 suppressed", 64'(q0.size()), 64'(n0));
    beat(0, 8'd108, 0);
    idle(2);
    chk("t4 out after", 64'(q0.size()), 64'(n0 + 1));
    chk("t4 first col", 64'(q0[q0.size()-1][39:0]), 64'h64686c);
    chk("t4 first idx", 64'(q0[q0.size()-1][49:40]), 64'h0);

    // Asynchronous reset mid-line with output valid
    beat(0, 8'd109, 0);
    beat(0, 8'd110, 0);
    @(negedge clk);
    chk("t5 valid before rst", 64'(valid[0]), 64'h1);
    #1 rst = 1'b1;
    #1;
    chk("t5 valid in rst", 64'(valid[0]), 64'h0);
    chk("t5 primed in rst", 64'(primed[0]), 64'h0);
    chk("t5 col in rst", 64'(col0), 64'h0);
    @(posedge clk); #1 rst = 1'b0;
    n0 = q0.size();
    for (int i = 0; i < 8; i++) beat(0, 8'(200 + i), 0);
    idle(2);
    chk("t5 suppressed", 64'(q0.size()), 64'(n0));
    beat(0, 8'd208, 0);
    idle(2);
    chk("t5 out after", 64'(q0.size()), 64'(n0 + 1));
    chk("t5 first col", 64'(q0[q0.size()-1][39:0]), 64'hc8ccd0);

    // Random valid/ready on all instances; the wide one runs 20 lines
    for (int d = 0; d < 3; d++) rr_en[d] = 1;
    fork
      rand_stream(2, 12800, 0);
      rand_stream(0, 400, 40);
      rand_stream(1, 400, 40);
    join
    for (int d = 0; d < 3; d++) begin rr_en[d] = 0; dn_ready[d] = 1; end
    idle(4);
    chk("t6 eol count", 64'(eolcnt2), 64'd20);
    chk("t6 primed", 64'(primed[2]), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
Parametrised, handshaked line buffer that turns a raster pixel stream into vertical pixel columns ROWS tall: the current pixel plus the same-column pixels from the previous ROWS-1 lines.
It sits between the camera/frame reader and the convolution/edge-detection kernel, which builds its 2-D window from consecutive columns.
Compared with the fixed 3-line shift-register buffer, it:
- uses circular line memories,
- uses valid/ready flow control on both sides,
- supports frame restart,
- has a selectable top-border mode.

Parameters:
DATA_W, 32, pixel width in bits
LINE_W, 640, pixels per line (>= 2)
ROWS, 3, column height / kernel rows (>= 2); ROWS-1 line memories are instantiated
PAD_MODE, 0, 0 = suppress output until ROWS-1 lines are stored; 1 = emit from the first line, with missing rows forced to zero
CW, $clog2(LINE_W), column index width (derived, not overridden)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_data  input  DATA_W  incoming pixel
in_data_valid  input  1  upstream beat valid
in_sof  input  1  start of frame, qualified by in_data_valid
ou_up_ready  output  1  block can accept a beat this cycle
ou_col  output  ROWS*DATA_W  column; bits [DATA_W-1:0] = current line, slice k = k lines above
ou_valid  output  1  ou_col and its tags are valid
in_dn_ready  input  1  downstream accepts the output beat
ou_col_idx  output  CW  column index of the output beat
ou_eol  output  1  output beat is the last column of its line
ou_primed  output  1  ROWS-1 complete lines are stored since the last sof/reset

Behaviour:
- Accept = in_data_valid && ou_up_ready.
- ou_up_ready = !ou_valid || in_dn_ready (combinational; one output register, no skid).
- Internal state: col counter (CW bits), lines_done counter (saturating at ROWS-1), memories mem[0..ROWS-2][0..LINE_W-1].
- On accept, with c = col value used for this beat:
  - Effective c = 0 and lines_done = 0 when in_sof = 1.
  - Otherwise c = current col and lines_done = current lines_done.
- Output column on accept:
  - slice 0 = in_data.
  - slice k (k >= 1) = mem[k-1][c] as read before this edge's write.
  - In PAD_MODE 1, slice k is forced to 0 when k > effective lines_done.
- Memory update on the same edge: mem[0][c] <= in_data; mem[k][c] <= mem[k-1][c] (old value).
- Counters on accept:
  - col <= (c == LINE_W-1) ? 0 : c+1.
  - When c == LINE_W-1, lines_done increments, saturating at ROWS-1.
  - With in_sof, the beat counts as col 0 of line 0, so col <= 1.
- Emit condition: PAD_MODE 1 always emits; PAD_MODE 0 emits only when effective lines_done == ROWS-1.
- Output register, next state:
  - Accept and emit: ou_valid <= 1; ou_col, ou_col_idx <= c, ou_eol <= (c == LINE_W-1) loaded.
  - Accept without emit: ou_valid <= 0. The beat is consumed, memories and counters advance, nothing is produced.
  - No accept and in_dn_ready: ou_valid <= 0.
  - No accept and !in_dn_ready: all outputs held.
- Output data and tags change only when (!ou_valid || in_dn_ready); they stay stable under backpressure.
- Latency: one clock from accept to ou_valid.
- ou_primed = (lines_done == ROWS-1), taken from the counter register. It falls on the cycle after an accepted sof beat.
- in_sof without in_data_valid is ignored.
- in_sof and col wrap on the same beat: the sof restart wins.
- Asynchronous reset, applied immediately with no clock edge needed:
  - ou_valid = 0, ou_col = 0, ou_col_idx = 0, ou_eol = 0, ou_primed = 0, col = 0, lines_done = 0.
  - Memories are not cleared; stale data is never emitted because of the masking/suppression rules above.
- Reset mid-line: the partial line is discarded, and the block re-primes from the next beat.
- Memory read is combinational or same-edge. The read-before-write ordering above is mandatory (RAM in read-first mode or registers).

Test Plan:
All tests use DATA_W=8, LINE_W=4, ROWS=3 unless stated.
1. PAD_MODE 0, sof on beat 1, pixels 1..12, in_dn_ready=1 -> no ou_valid for beats 1-8. Beat 9 gives ou_col={1,5,9} (slice2,slice1,slice0), col_idx 0, next cycle. Beat 12 gives {4,8,12} with ou_eol=1. ou_primed rises after beat 8.
2. PAD_MODE 1, same stream -> beat 1 gives {0,0,1}, beat 5 gives {0,1,5}, beat 9 gives {1,5,9}. One output per input, in order.
3. Backpressure: in_dn_ready=0 for 3 cycles while the source is valid -> ou_up_ready=0 and ou_col/ou_valid held. After release the sequence continues with no duplicate or lost beat (scoreboard against a reference model).
4. PAD_MODE 0, in_sof on the 3rd pixel of line 3 (value 100) -> ou_primed=0 next cycle. The next 8 beats, including 100, are suppressed. The first emitted column is {100, x+4, x+8} relative to the new frame.
5. rst pulsed asynchronously mid-line while ou_valid=1 -> ou_valid and ou_primed drop before the next clk edge. After release, PAD_MODE 0 needs 8 beats before output, and no pre-reset data appears.
6. Random valid/ready over 20 lines, LINE_W=640, ROWS=5, PAD_MODE 1 -> col wraps 639->0 and lines_done saturates at 4. All columns match the model, and ou_eol asserts exactly on col_idx 639.
